// File: rtl/dcache_mem_bridge_pkg.sv
// Shared constants, FSM encoding and beat-address helper for the dcache memory bridge.
package dcache_mem_bridge_pkg;

    localparam int LINE_WORDS      = 16;
    localparam int LINE_BITS       = 512;
    localparam int WORD_BITS       = 32;
    localparam int OFFSET_BITS     = 6;
    localparam int CNT_BITS        = 5;
    localparam int DEF_OUTSTANDING = 4;

    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(LINE_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    function automatic logic [31:0] beat_addr(input logic [31-OFFSET_BITS:0] base,
                                              input logic [3:0] word);
        return {base, word, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_mem_bridge_line_buf.sv
// 16x32 line buffer: word write/read ports plus whole-line parallel load and read.
module dcache_mem_bridge_line_buf
    import dcache_mem_bridge_pkg::*;
(
    input  logic                 clk,
    input  logic                 load_en,
    input  logic [LINE_BITS-1:0] load_data,
    input  logic                 wr_en,
    input  logic [3:0]           wr_idx,
    input  logic [WORD_BITS-1:0] wr_data,
    input  logic [3:0]           rd_idx,
    output logic [WORD_BITS-1:0] rd_data,
    output logic [LINE_BITS-1:0] line_data
);

    logic [WORD_BITS-1:0] mem_q [LINE_WORDS];

    // NOTE: the array has no reset; every word is written by a load or a refill before it is read.
    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                mem_q[i] <= load_data[i*WORD_BITS +: WORD_BITS];
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++) begin
            line_data[i*WORD_BITS +: WORD_BITS] = mem_q[i];
        end
    end

endmodule

// File: rtl/dcache_mem_bridge.sv
// Line-to-beat bridge between the data cache and the 32-bit memory bus.
// Optional DCACHE_BRIDGE_CRIT_WORD_FIRST_EN: refills start at the requested word and wrap.
module dcache_mem_bridge
    import dcache_mem_bridge_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_OUTSTANDING
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 line_addr_valid,
    input  logic [31:0]          line_addr,
    input  logic                 line_wdata_valid,
    input  logic [LINE_BITS-1:0] line_wdata,
    output logic                 line_rdata_ready,
    output logic [LINE_BITS-1:0] line_rdata,
    output logic                 line_write_done,
    output logic                 busy,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [31:0]          bus_addr,
    output logic [WORD_BITS-1:0] bus_wdata,
    input  logic                 bus_gnt,
    input  logic                 bus_rvalid,
    input  logic [WORD_BITS-1:0] bus_rdata
);

    state_e                    state_q, state_d;
    logic [31-OFFSET_BITS:0]   base_q, base_d;
    logic [3:0]                start_q, start_d;
    logic [CNT_BITS-1:0]       req_cnt_q, req_cnt_d;
    logic [CNT_BITS-1:0]       rsp_cnt_q, rsp_cnt_d;

    logic [CNT_BITS-1:0]       outstanding;
    logic                      rd_issue;
    logic                      rsp_fire;
    logic                      load_en;
    logic [WORD_BITS-1:0]      buf_rd_data;
    logic [LINE_BITS-1:0]      buf_line;
    logic                      addr_unused;

`ifdef DCACHE_BRIDGE_CRIT_WORD_FIRST_EN
    assign addr_unused = ^line_addr[1:0];
`else
    assign addr_unused = ^line_addr[5:0];
`endif

    assign outstanding = req_cnt_q - rsp_cnt_q;
    assign rd_issue    = (state_q == ST_RD) && (req_cnt_q < CNT_FULL)
                       && (outstanding < CNT_BITS'(MAX_OUTSTANDING));
    assign rsp_fire    = (state_q == ST_RD) && bus_rvalid && (rsp_cnt_q < CNT_FULL);
    assign load_en     = (state_q == ST_IDLE) && line_addr_valid && line_wdata_valid;

    dcache_mem_bridge_line_buf u_line_buf (
        .clk       (clk),
        .load_en   (load_en),
        .load_data (line_wdata),
        .wr_en     (rsp_fire),
        .wr_idx    (start_q + rsp_cnt_q[3:0]),
        .wr_data   (bus_rdata),
        .rd_idx    (req_cnt_q[3:0]),
        .rd_data   (buf_rd_data),
        .line_data (buf_line)
    );

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            start_q   <= '0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            start_q   <= start_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        start_d   = start_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        case (state_q)
            ST_IDLE: begin
                req_cnt_d = '0;
                rsp_cnt_d = '0;
                if (line_addr_valid) begin
                    base_d = line_addr[31:OFFSET_BITS];
                    if (line_wdata_valid) begin
                        start_d = 4'd0;
                        state_d = ST_WR;
                    end else begin
`ifdef DCACHE_BRIDGE_CRIT_WORD_FIRST_EN
                        start_d = line_addr[5:2];
`else
                        start_d = 4'd0;
`endif
                        state_d = ST_RD;
                    end
                end
            end
            ST_WR: begin
                if (bus_req && bus_gnt) req_cnt_d = req_cnt_q + 1'b1;
                if (req_cnt_q == CNT_FULL) state_d = ST_IDLE;
            end
            ST_RD: begin
                if (bus_req && bus_gnt) req_cnt_d = req_cnt_q + 1'b1;
                if (rsp_fire) rsp_cnt_d = rsp_cnt_q + 1'b1;
                if (rsp_fire && rsp_cnt_q == CNT_FULL - 1'b1) state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are gated to zero outside their active state so reset leaves everything low.
    always_comb begin
        busy             = (state_q != ST_IDLE);
        bus_req          = 1'b0;
        bus_we           = 1'b0;
        bus_addr         = '0;
        bus_wdata        = '0;
        line_write_done  = 1'b0;
        line_rdata_ready = 1'b0;
        line_rdata       = '0;
        case (state_q)
            ST_WR: begin
                if (req_cnt_q < CNT_FULL) begin
                    bus_req   = 1'b1;
                    bus_we    = 1'b1;
                    bus_addr  = beat_addr(base_q, req_cnt_q[3:0]);
                    bus_wdata = buf_rd_data;
                end else begin
                    line_write_done = 1'b1;
                end
            end
            ST_RD: begin
                if (rd_issue) begin
                    bus_req  = 1'b1;
                    bus_addr = beat_addr(base_q, start_q + req_cnt_q[3:0]);
                end
            end
            ST_RESP: begin
                line_rdata_ready = 1'b1;
                line_rdata       = buf_line;
            end
            default: ;
        endcase
    end

endmodule
